// File: rtl/axil_ram_master_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite RAM initiator:
//   - default address/data widths
//   - AXI-Lite response codes (OKAY / SLVERR / DECERR)
//   - FSM state encoding of axil_ram_master
//   - small helper for classifying response codes
// -----------------------------------------------------------------------------
package axil_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_ADDR      = 3'd1,
        RD_DATA      = 3'd2,
        WR_ADDR_DATA = 3'd3,
        WR_RESP      = 3'd4,
        RESP         = 3'd5
    } state_t;

    // True for the two error codes a responder can return.
    function automatic logic resp_is_error(input logic [1:0] code);
        return (code == RESP_SLVERR) || (code == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_ram_master_if.sv
// -----------------------------------------------------------------------------
// axil_ram_master_if
// AXI4-Lite bus between the RAM initiator (master modport) and the RAM
// responder (slave modport). Channels: AW, W, B, AR, R.
// Parameters: ADDR_W (address width), DATA_W (data width, strobes DATA_W/8).
// -----------------------------------------------------------------------------
interface axil_ram_master_if
    import axil_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W
) ();

    localparam int STRB_W = DATA_W / 8;

    // AW channel
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    // W channel
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    // B channel
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    // AR channel
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    // R channel
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

endinterface

// File: rtl/axil_ram_master.sv
// -----------------------------------------------------------------------------
// axil_ram_master
// AXI4-Lite initiator used by the core's memory stage to reach the RAM bus.
// One load/store at a time: a request is taken on the req_* port, the matching
// AW/W/B or AR/R transfer is run on the ram interface, and the read data plus
// response code are returned on the resp_* port.
//
// Ports:
//   clock, reset_n            clock; asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_we/addr/wdata/wstrb   request contents (we=1 write, 0 read)
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_code      read data (0 for writes) and bus response code
//   ram                       AXI4-Lite master modport (axil_ram_master_if)
//
// Optional feature, macro AXIL_RAM_MASTER_ALIGN_CHECK_EN:
//   when defined, a request with req_addr[1:0]!=0, or a write with
//   req_wstrb==0, is answered with SLVERR straight from IDLE with no bus
//   activity. When undefined, every request is forwarded as-is.
// -----------------------------------------------------------------------------
module axil_ram_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_code,
    axil_ram_master_if.master   ram
);

    localparam int STRB_W = DATA_W / 8;

    state_t             state_reg,   state_next;
    logic [ADDR_W-1:0]  addr_reg,    addr_next;
    logic [DATA_W-1:0]  wdata_reg,   wdata_next;
    logic [STRB_W-1:0]  wstrb_reg,   wstrb_next;
    logic [DATA_W-1:0]  rdata_reg,   rdata_next;
    logic [1:0]         code_reg,    code_next;
    logic               aw_done_reg, aw_done_next;
    logic               w_done_reg,  w_done_next;

    // ------------------------------------------------------------------
    // Outputs: decoded from the state and done-flag registers only, so no
    // path exists from req_* to the bus pins.
    // ------------------------------------------------------------------
    assign req_ready   = (state_reg == IDLE);
    assign resp_valid  = (state_reg == RESP);
    assign resp_rdata  = rdata_reg;
    assign resp_code   = code_reg;

    assign ram.arvalid = (state_reg == RD_ADDR);
    assign ram.araddr  = addr_reg;
    assign ram.rready  = (state_reg == RD_DATA);

    // AW and W are raised together on entry and each drops only after its
    // own handshake, so a responder that waits for AW before accepting W
    // cannot deadlock us.
    assign ram.awvalid = (state_reg == WR_ADDR_DATA) && !aw_done_reg;
    assign ram.awaddr  = addr_reg;
    assign ram.wvalid  = (state_reg == WR_ADDR_DATA) && !w_done_reg;
    assign ram.wdata   = wdata_reg;
    assign ram.wstrb   = wstrb_reg;
    assign ram.bready  = (state_reg == WR_RESP);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        rdata_next   = rdata_reg;
        code_next    = code_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;

        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_we ? req_wdata : '0;
                    wstrb_next = req_we ? req_wstrb : '0;
                    rdata_next = '0;
                    code_next  = RESP_OKAY;
`ifdef AXIL_RAM_MASTER_ALIGN_CHECK_EN
                    if ((req_addr[1:0] != 2'b00) || (req_we && (req_wstrb == '0))) begin
                        // Rejected locally: no bus traffic, error reply next cycle.
                        state_next = RESP;
                        code_next  = RESP_SLVERR;
                    end else if (req_we) begin
                        state_next = WR_ADDR_DATA;
                    end else begin
                        state_next = RD_ADDR;
                    end
`else
                    if (req_we) begin
                        state_next = WR_ADDR_DATA;
                    end else begin
                        state_next = RD_ADDR;
                    end
`endif
                end
            end

            RD_ADDR: begin
                if (ram.arready) begin
                    state_next = RD_DATA;
                end
            end

            RD_DATA: begin
                if (ram.rvalid) begin
                    rdata_next = ram.rdata;
                    code_next  = ram.rresp;
                    state_next = RESP;
                end
            end

            WR_ADDR_DATA: begin
                // A ready seen after the flag is set is ignored because the
                // matching valid is already low.
                aw_done_next = aw_done_reg | ram.awready;
                w_done_next  = w_done_reg  | ram.wready;
                // Leave as soon as both complete, including when both
                // handshakes land in the same cycle.
                if (aw_done_next && w_done_next) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (ram.bvalid) begin
                    code_next  = ram.bresp;
                    rdata_next = '0;
                    state_next = RESP;
                end
            end

            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset abandons any transaction in flight without
    // producing a response.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            code_reg    <= RESP_OKAY;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            rdata_reg   <= rdata_next;
            code_reg    <= code_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

endmodule

// File: tb/tb_axil_ram_master.sv
// -----------------------------------------------------------------------------
// tb_axil_ram_master
// Directed bench for axil_ram_master with a small AXI4-Lite responder model.
// Responder knobs: random 0-3 cycle ready delays, W held until AW completes,
// AR stall, programmable rdata/rresp/bresp. A bus monitor counts handshakes
// and flags any valid that drops or changes payload before its handshake.
// Build with +define+AXIL_RAM_MASTER_ALIGN_CHECK_EN to cover the alignment
// rejection path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_ram_master;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;

    always #5 clk = ~clk;

    axil_ram_master_if #(.ADDR_W(32), .DATA_W(32)) ram_if ();

    axil_ram_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_code  (resp_code),
        .ram        (ram_if)
    );

    // ---------------------------------------------------------------- responder
    bit          rand_dly   = 1'b0;
    bit          w_after_aw = 1'b0;
    bit          ar_hold    = 1'b0;
    logic [31:0] rd_val     = '0;
    logic [1:0]  rresp_val  = 2'b00;
    logic [1:0]  bresp_val  = 2'b00;

    logic [3:0]  ar_cnt, aw_cnt, w_cnt;
    logic        aw_got, w_got;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          ar_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, r_hs_cnt = 0;

    assign ram_if.arready = ram_if.arvalid && (ar_cnt == 4'd0) && !ar_hold;
    assign ram_if.awready = ram_if.awvalid && (aw_cnt == 4'd0);
    assign ram_if.wready  = ram_if.wvalid  && (w_cnt  == 4'd0) && (!w_after_aw || aw_got);

    function automatic logic [3:0] pick_dly();
        return rand_dly ? 4'($urandom_range(0, 3)) : 4'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt        <= '0;
            aw_cnt        <= '0;
            w_cnt         <= '0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            ram_if.rvalid <= 1'b0;
            ram_if.rdata  <= '0;
            ram_if.rresp  <= 2'b00;
            ram_if.bvalid <= 1'b0;
            ram_if.bresp  <= 2'b00;
        end else begin
            if (ram_if.arvalid && ram_if.arready) begin
                ar_cnt        <= pick_dly();
                cap_araddr    <= ram_if.araddr;
                ram_if.rvalid <= 1'b1;
                ram_if.rdata  <= rd_val;
                ram_if.rresp  <= rresp_val;
                ar_hs_cnt     <= ar_hs_cnt + 1;
            end else if (ram_if.arvalid && ar_cnt != 4'd0) begin
                ar_cnt <= ar_cnt - 4'd1;
            end
            if (ram_if.rvalid && ram_if.rready) begin
                ram_if.rvalid <= 1'b0;
                r_hs_cnt      <= r_hs_cnt + 1;
            end

            if (ram_if.awvalid && ram_if.awready) begin
                aw_cnt     <= pick_dly();
                cap_awaddr <= ram_if.awaddr;
                aw_hs_cnt  <= aw_hs_cnt + 1;
            end else if (ram_if.awvalid && aw_cnt != 4'd0) begin
                aw_cnt <= aw_cnt - 4'd1;
            end
            if (ram_if.wvalid && ram_if.wready) begin
                w_cnt     <= pick_dly();
                cap_wdata <= ram_if.wdata;
                cap_wstrb <= ram_if.wstrb;
                w_hs_cnt  <= w_hs_cnt + 1;
            end else if (ram_if.wvalid && w_cnt != 4'd0) begin
                w_cnt <= w_cnt - 4'd1;
            end

            if ((aw_got || (ram_if.awvalid && ram_if.awready)) &&
                (w_got  || (ram_if.wvalid  && ram_if.wready))) begin
                aw_got        <= 1'b0;
                w_got         <= 1'b0;
                ram_if.bvalid <= 1'b1;
                ram_if.bresp  <= bresp_val;
            end else begin
                if (ram_if.awvalid && ram_if.awready) aw_got <= 1'b1;
                if (ram_if.wvalid  && ram_if.wready)  w_got  <= 1'b1;
            end
            if (ram_if.bvalid && ram_if.bready) begin
                ram_if.bvalid <= 1'b0;
                b_hs_cnt      <= b_hs_cnt + 1;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    int          viol = 0;
    int          arv_cycles = 0;
    logic        p_ar, p_aw, p_w, p_resp;
    logic [31:0] p_araddr, p_awaddr, p_wdata, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_code;

    always @(posedge clk or negedge rst_n) begin
        int v;
        if (!rst_n) begin
            p_ar   <= 1'b0;
            p_aw   <= 1'b0;
            p_w    <= 1'b0;
            p_resp <= 1'b0;
        end else begin
            v = 0;
            if (p_ar && (!ram_if.arvalid || ram_if.araddr != p_araddr)) v++;
            if (p_aw && (!ram_if.awvalid || ram_if.awaddr != p_awaddr)) v++;
            if (p_w  && (!ram_if.wvalid  || ram_if.wdata != p_wdata || ram_if.wstrb != p_wstrb)) v++;
            if (p_resp && (!resp_valid || resp_rdata != p_rdata || resp_code != p_code)) v++;
            viol       <= viol + v;
            arv_cycles <= arv_cycles + (ram_if.arvalid ? 1 : 0);
            p_ar     <= ram_if.arvalid && !ram_if.arready;
            p_aw     <= ram_if.awvalid && !ram_if.awready;
            p_w      <= ram_if.wvalid  && !ram_if.wready;
            p_resp   <= resp_valid && !resp_ready;
            p_araddr <= ram_if.araddr;
            p_awaddr <= ram_if.awaddr;
            p_wdata  <= ram_if.wdata;
            p_wstrb  <= ram_if.wstrb;
            p_rdata  <= resp_rdata;
            p_code   <= resp_code;
        end
    end

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Offer a request at a negedge; returns just after the accepting edge.
    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        for (int n = 0; n < 50; n++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat = 1 means resp_valid was already high right after the accept edge.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit ok;
        int lat, aw0, w0, b0, a0, bad, rr_bad, stray;
        int e_to, e_code, e_rd, e_data;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [1:0]  exp_code;

        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  req_ready,      1);
        check("rst_arvalid",    ram_if.arvalid, 0);
        check("rst_awvalid",    ram_if.awvalid, 0);
        check("rst_wvalid",     ram_if.wvalid,  0);
        check("rst_bready",     ram_if.bready,  0);
        check("rst_rready",     ram_if.rready,  0);
        check("rst_resp_valid", resp_valid,     0);
        check("rst_resp_rdata", resp_rdata,     0);
        check("rst_resp_code",  resp_code,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read, zero wait
        rd_val = 32'hDEADBEEF; rresp_val = RESP_OKAY;
        send(1'b0, 32'h80000010, 32'h0, 4'h0, ok);
        check("rd_accept",  ok, 1);
        check("rd_arvalid", ram_if.arvalid, 1);
        check("rd_araddr",  ram_if.araddr,  32'h80000010);
        wait_resp(lat);
        check("rd_latency", lat, 3);
        check("rd_rdata",   resp_rdata, 32'hDEADBEEF);
        check("rd_code",    resp_code,  RESP_OKAY);
        $display("txn read  addr=80000010 rdata=%h code=%b lat=%0d", resp_rdata, resp_code, lat);
        take_resp();
        check("rd_resp_drop", resp_valid, 0);
        check("rd_idle",      req_ready,  1);

        // Write, AW and W complete in the same cycle
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; bresp_val = RESP_OKAY;
        send(1'b1, 32'h80000020, 32'h12345678, 4'hF, ok);
        check("wr_awvalid", ram_if.awvalid, 1);
        check("wr_wvalid",  ram_if.wvalid,  1);
        wait_resp(lat);
        check("wr_latency", lat, 3);
        check("wr_code",    resp_code,  RESP_OKAY);
        check("wr_rdata",   resp_rdata, 0);
        check("wr_awaddr",  cap_awaddr, 32'h80000020);
        check("wr_wdata",   cap_wdata,  32'h12345678);
        check("wr_wstrb",   cap_wstrb,  4'hF);
        $display("txn write addr=80000020 wdata=12345678 code=%b lat=%0d", resp_code, lat);
        take_resp();
        repeat (3) @(posedge clk);
        #1;
        check("wr_aw_beats", aw_hs_cnt - aw0, 1);
        check("wr_w_beats",  w_hs_cnt - w0,   1);
        check("wr_b_beats",  b_hs_cnt - b0,   1);

        // DECERR read, consumer stalls for 5 cycles
        rd_val = 32'hCAFEF00D; rresp_val = RESP_DECERR;
        send(1'b0, 32'h90000000, 32'h0, 4'h0, ok);
        wait_resp(lat);
        check("dec_valid", resp_valid, 1);
        check("dec_code",  resp_code,  RESP_DECERR);
        check("dec_rdata", resp_rdata, 32'hCAFEF00D);
        bad = 0; rr_bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!resp_valid || resp_code != RESP_DECERR || resp_rdata != 32'hCAFEF00D) bad++;
            if (req_ready) rr_bad++;
        end
        check("dec_hold_stable", bad, 0);
        check("dec_hold_busy",   rr_bad, 0);
        $display("txn read  addr=90000000 rdata=%h code=%b err=%0d", resp_rdata, resp_code,
                 resp_is_error(resp_code));
        take_resp();
        rresp_val = RESP_OKAY;

        // 1000 writes against a responder that holds W until AW is done
        rand_dly = 1'b1; w_after_aw = 1'b1;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        e_to = 0; e_code = 0; e_rd = 0; e_data = 0;
        for (int i = 0; i < 1000; i++) begin
            wd        = $urandom;
            st        = 4'($urandom_range(1, 15));
            exp_code  = 2'($urandom_range(0, 3));
            bresp_val = exp_code;
            send(1'b1, 32'h80000000 + 32'(i * 4), wd, st, ok);
            wait_resp(lat);
            if (!ok || !resp_valid) e_to++;
            if (resp_code != exp_code) e_code++;
            if (resp_rdata != 32'h0) e_rd++;
            if (cap_wdata != wd || cap_wstrb != st || cap_awaddr != 32'h80000000 + 32'(i * 4)) e_data++;
            take_resp();
        end
        $display("txn write loop 1000 ordered-W writes, timeouts=%0d", e_to);
        check("loop_timeouts", e_to,   0);
        check("loop_code",     e_code, 0);
        check("loop_rdata",    e_rd,   0);
        check("loop_payload",  e_data, 0);
        check("loop_aw_beats", aw_hs_cnt - aw0, 1000);
        check("loop_w_beats",  w_hs_cnt - w0,   1000);
        check("loop_b_beats",  b_hs_cnt - b0,   1000);
        rand_dly = 1'b0; w_after_aw = 1'b0;

        // Reset in the middle of a read address phase
        ar_hold = 1'b1;
        send(1'b0, 32'h80000040, 32'h0, 4'h0, ok);
        check("mid_arvalid_before", ram_if.arvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_arvalid_async", ram_if.arvalid, 0);
        check("mid_rready_async",  ram_if.rready,  0);
        check("mid_resp_valid",    resp_valid,     0);
        ar_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid || ram_if.arvalid) stray++;
        end
        check("mid_no_stray",   stray, 0);
        check("mid_req_ready",  req_ready, 1);
        $display("txn read  addr=80000040 dropped by reset");

        // Normal read after reset
        rd_val = 32'hA5A5A5A5;
        send(1'b0, 32'h80000050, 32'h0, 4'h0, ok);
        wait_resp(lat);
        check("post_rst_rdata", resp_rdata, 32'hA5A5A5A5);
        check("post_rst_araddr", cap_araddr, 32'h80000050);
        $display("txn read  addr=80000050 rdata=%h code=%b lat=%0d", resp_rdata, resp_code, lat);
        take_resp();

        // Misaligned read
`ifdef AXIL_RAM_MASTER_ALIGN_CHECK_EN
        a0 = arv_cycles;
        send(1'b0, 32'h80000002, 32'h0, 4'h0, ok);
        wait_resp(lat);
        check("align_rd_latency", lat, 1);
        check("align_rd_code",    resp_code,  RESP_SLVERR);
        check("align_rd_rdata",   resp_rdata, 0);
        $display("txn read  addr=80000002 rejected code=%b lat=%0d", resp_code, lat);
        take_resp();
        check("align_rd_no_ar", arv_cycles - a0, 0);
        aw0 = aw_hs_cnt;
        send(1'b1, 32'h80000030, 32'h11111111, 4'h0, ok);
        wait_resp(lat);
        check("align_wr_latency", lat, 1);
        check("align_wr_code",    resp_code, RESP_SLVERR);
        $display("txn write addr=80000030 strb=0 rejected code=%b", resp_code);
        take_resp();
        check("align_wr_no_aw", aw_hs_cnt - aw0, 0);
`else
        rd_val = 32'h0BADF00D;
        send(1'b0, 32'h80000002, 32'h0, 4'h0, ok);
        check("unalign_arvalid", ram_if.arvalid, 1);
        check("unalign_araddr",  ram_if.araddr,  32'h80000002);
        wait_resp(lat);
        check("unalign_code",  resp_code,  RESP_OKAY);
        check("unalign_rdata", resp_rdata, 32'h0BADF00D);
        $display("txn read  addr=80000002 forwarded rdata=%h code=%b", resp_rdata, resp_code);
        take_resp();
`endif

        check("axi_stability", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_ram_master.md
Name: axil_ram_master

Overview:
- AXI4-Lite initiator that the core uses to reach the RAM bus. It is the other end of the simulation RAM responder.
- Accepts one load/store request at a time on a valid/ready request port and drives the AW/W/B and AR/R channels.
- Returns read data and the response code on a valid/ready response port.
- Sits between the core's memory stage and the `io_ram_*` pins.

Parameters:
- ADDR_W, 32, address width of the request port and the AW/AR channels.
- DATA_W, 32, data width. STRB_W = DATA_W/8 is derived from it.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request offered
- req_ready  out  1  block is idle and can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  STRB_W  write byte strobes
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_W  read data; 0 for writes
- resp_code  out  2  OKAY=00, SLVERR=10, DECERR=11
- ram_awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AXI-Lite AW channel
- ram_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/STRB_W  AXI-Lite W channel
- ram_bvalid/bready/bresp  in/out/in  1/1/2  AXI-Lite B channel
- ram_arvalid/arready/araddr  out/in/out  1/1/ADDR_W  AXI-Lite AR channel
- ram_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  AXI-Lite R channel

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All valid outputs 0; bready=rready=0; resp_rdata=0; resp_code=00.
  - Address/data registers cleared to 0.
  - Reset mid-transaction drops it silently. No response is produced.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP.
- req_ready = (state==IDLE). The request is captured into registers on req_valid&&req_ready.
  - Read: go to RD_ADDR.
  - Write: go to WR_ADDR_DATA.
- All bus outputs are driven from registers, never combinationally from req_*.
- RD_ADDR:
  - arvalid=1, araddr=captured address.
  - On arready, drop arvalid and go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, latch rdata into resp_rdata and rresp into resp_code, then go to RESP.
- WR_ADDR_DATA:
  - awvalid and wvalid are both raised on entry.
  - Each is held independently until its own handshake; aw_done/w_done flags record completion.
  - Both handshakes in the same cycle is legal.
  - The responder may withhold wready until AW completes; no deadlock is allowed.
  - When both flags are set, clear them and go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, resp_code=bresp, resp_rdata=0, then go to RESP.
- RESP:
  - resp_valid=1, with rdata and code stable.
  - On resp_ready, go to IDLE.
  - resp_valid is held indefinitely while resp_ready=0.
- Minimum latency: request accept to resp_valid is 3 cycles for a read with zero-wait handshakes, and 3 cycles for a write.
- Valid outputs never drop before their handshake (AXI rule).
- Address and data are stable while valid is high.
- One outstanding transaction only. No new request is accepted until the response is consumed.
- Non-OKAY bus responses are passed through unchanged. The block does not retry.

Optional Feature:
- Macro: AXIL_RAM_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request whose req_addr[1:0]!=0 is rejected without any bus activity.
  - It is accepted and goes IDLE to RESP directly, with resp_code=SLVERR and resp_rdata=0, resp_valid one cycle after acceptance.
  - For writes, a strobe check also applies: req_wstrb==0 gets the same treatment.
- Not defined: addresses are forwarded unaligned; the responder decides.

Decomposition:
- Package axil_pkg holds:
  - Response code constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The state encoding.
  - ADDR_W/DATA_W defaults.
- No sub-module. The single FSM plus the aw_done/w_done flags is small enough to stay flat.

Test Plan:
- Read, zero wait: req read at 0x80000010; responder returns rdata 0xDEADBEEF, rresp 00 → arvalid 1 cycle after accept, araddr 0x80000010, resp_valid with rdata 0xDEADBEEF, code 00.
- Write, AW-before-W responder (wready only after AW handshake, random 0-3 delay): write 0x12345678 strb 0xF at 0x80000020 → W handshake after AW, bready seen, resp code 00, rdata 0, no deadlock over 1000 random iterations.
- Simultaneous AW/W handshake in one cycle → FSM goes to WR_RESP exactly once, no duplicate W beat.
- DECERR: read at 0x90000000 with responder rresp=11 → resp_code 11. Hold resp_ready=0 for 5 cycles → resp_valid and data stable, req_ready=0 throughout.
- Reset mid-transaction: assert reset_n=0 while arvalid=1 → all valids 0 immediately (async). After release, req_ready=1 and no stray resp_valid.
- With AXIL_RAM_MASTER_ALIGN_CHECK_EN: read at 0x80000002 → no arvalid ever, resp_code 10 next cycle. Without the macro → arvalid with araddr 0x80000002.
